// File: rtl/dk_upload_pkg.sv
// dk_upload_pkg: shared types and constants for the ioctl upload responder.
//   dk_upload_state_e : FSM state encoding (IDLE, FETCH, DONE)
//   FILL_BYTE         : byte returned for reads past the payload
//   TIMEOUT_BYTE      : byte returned when memory never acknowledges
//   csum_close()      : byte that brings an 8-bit running sum back to zero
package dk_upload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } dk_upload_state_e;

  localparam logic [7:0] FILL_BYTE    = 8'hFF;
  localparam logic [7:0] TIMEOUT_BYTE = 8'h00;

  function automatic logic [7:0] csum_close(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/dk_upload_csum.sv
// dk_upload_csum: 8-bit modulo-256 accumulator of served upload bytes.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : zero the accumulator (wins over i_add)
//   i_add, i_data  : add i_data to the sum this cycle
//   o_neg          : two's-complement negation of the current sum
module dk_upload_csum
  import dk_upload_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic [7:0] o_neg
);

  logic [7:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_neg = csum_close(r_sum);

endmodule

// File: rtl/dk_ioctl_upload.sv
// dk_ioctl_upload: upload-side responder for the HPS ioctl channel.
// Serves each ioctl_rd byte request of an upload on index INDEX from a
// variable-latency core memory port, stalling the host with ioctl_wait.
//
// Optional feature macro: DK_UPLOAD_CSUM_EN -- a read at address LEN
// returns the byte that makes the served payload sum to zero mod 256.
//
// Ports:
//   clk_sys, reset_n        : clock, asynchronous active-low reset
//   ioctl_upload/index      : upload in progress / target index
//   ioctl_rd, ioctl_addr    : one-cycle read strobe and byte address
//   ioctl_din, ioctl_wait   : returned byte, host stall
//   mem_req, mem_addr       : level request to core memory and its address
//   mem_ack, mem_dout       : one-cycle data valid and data from memory
//   busy, err               : FSM not idle, sticky timeout flag
//   o_dbg_state             : current FSM state
//
// Handshakes:
//   host side  : ioctl_rd is a single-cycle strobe, accepted only in IDLE
//                while active; ioctl_wait rises the cycle after an in-range
//                strobe and falls in the cycle ioctl_din becomes valid.
//   memory side: mem_req is a level held with mem_addr stable until the
//                cycle after mem_ack; mem_dout is taken only with mem_ack
//                while in FETCH.
module dk_ioctl_upload
  import dk_upload_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter logic [15:0] LEN     = 16'h0100,
  parameter logic [7:0]  INDEX   = 8'd4,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              err,
  output dk_upload_state_e  o_dbg_state
);

  localparam logic [24:0] LEN_EXT = 25'(LEN);
  // The counter sits at TIMEOUT-1 in the last FETCH cycle, so wait drops
  // exactly TIMEOUT cycles after entering FETCH.
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  dk_upload_state_e  r_state, w_state_nxt;
  logic              r_active_q;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        r_din, w_din_nxt;
  logic              r_wait, w_wait_nxt;
  logic              r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_err, w_err_nxt;
  logic              w_active;
  logic              w_start;
  logic              w_in_range;

  assign w_active   = ioctl_upload && (ioctl_index == INDEX);
  assign w_start    = w_active && !r_active_q;
  assign w_in_range = ioctl_addr < LEN_EXT;

`ifdef DK_UPLOAD_CSUM_EN
  logic       w_csum_add;
  logic [7:0] w_csum_data;
  logic [7:0] w_csum_neg;

  dk_upload_csum u_csum (
    .i_clk  (clk_sys),
    .i_rst_n(reset_n),
    .i_clr  (w_start),
    .i_add  (w_csum_add),
    .i_data (w_csum_data),
    .o_neg  (w_csum_neg)
  );
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_din_nxt   = r_din;
    w_wait_nxt  = r_wait;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_err_nxt   = r_err;
`ifdef DK_UPLOAD_CSUM_EN
    w_csum_add  = 1'b0;
    w_csum_data = mem_dout;
`endif

    if (w_start) begin
      w_err_nxt = 1'b0;
      w_cnt_nxt = 8'd0;
    end

    if (!w_active) begin
      // Abort from any state; ioctl_din deliberately keeps its value.
      w_state_nxt = ST_IDLE;
      w_req_nxt   = 1'b0;
      w_wait_nxt  = 1'b0;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ioctl_rd) begin
            if (w_in_range) begin
              w_addr_nxt  = ioctl_addr[ADDR_W-1:0];
              w_req_nxt   = 1'b1;
              w_wait_nxt  = 1'b1;
              w_cnt_nxt   = 8'd0;
              w_state_nxt = ST_FETCH;
            end else begin
`ifdef DK_UPLOAD_CSUM_EN
              if (ioctl_addr == LEN_EXT) begin
                // On the start cycle the accumulator is being cleared.
                w_din_nxt = w_start ? 8'h00 : w_csum_neg;
              end else begin
                w_din_nxt = FILL_BYTE;
              end
`else
              w_din_nxt = FILL_BYTE;
`endif
            end
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            w_din_nxt   = mem_dout;
            w_req_nxt   = 1'b0;
            w_wait_nxt  = 1'b0;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_DONE;
`ifdef DK_UPLOAD_CSUM_EN
            w_csum_add  = 1'b1;
`endif
          end else if (r_cnt == TO_LAST) begin
            w_din_nxt   = TIMEOUT_BYTE;
            w_err_nxt   = 1'b1;
            w_req_nxt   = 1'b0;
            w_wait_nxt  = 1'b0;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_DONE;
`ifdef DK_UPLOAD_CSUM_EN
            // A timed-out byte still counts as served.
            w_csum_add  = 1'b1;
            w_csum_data = TIMEOUT_BYTE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // Guard cycle before the next host strobe may be accepted.
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
          w_wait_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_active_q <= 1'b0;
      r_cnt      <= 8'd0;
      r_din      <= 8'h00;
      r_wait     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_active_q <= w_active;
      r_cnt      <= w_cnt_nxt;
      r_din      <= w_din_nxt;
      r_wait     <= w_wait_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ioctl_din   = r_din;
  assign ioctl_wait  = r_wait;
  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dk_ioctl_upload.sv
// tb_dk_ioctl_upload: directed bench for dk_ioctl_upload.
// Instance a uses LEN=256; instance b uses LEN=3 for the checksum byte.
// Only one instance is active (upload asserted) at a time.
module tb_dk_ioctl_upload;
  import dk_upload_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  // ---------------- stimulus ----------------
  logic        ioctl_upload;
  logic        ioctl_upload_b;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  // ---------------- DUT outputs ----------------
  logic [7:0]  din_a, din_b;
  logic        wait_a, wait_b, req_a, req_b, busy_a, busy_b, err_a, err_b;
  logic [15:0] addr_a, addr_b;
  dk_upload_state_e st_a, st_b;

  dk_ioctl_upload u_dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din_a), .ioctl_wait(wait_a),
    .mem_req(req_a), .mem_addr(addr_a),
    .mem_ack(mem_ack), .mem_dout(mem_dout),
    .busy(busy_a), .err(err_a), .o_dbg_state(st_a)
  );

  dk_ioctl_upload #(.LEN(16'd3)) u_dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload_b), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din_b), .ioctl_wait(wait_b),
    .mem_req(req_b), .mem_addr(addr_b),
    .mem_ack(mem_ack), .mem_dout(mem_dout),
    .busy(busy_b), .err(err_b), .o_dbg_state(st_b)
  );

  // Observation mux so one set of driver tasks serves both instances.
  logic        sel_b;
  logic [7:0]  obs_din;
  logic        obs_wait, obs_req, obs_busy, obs_err;
  logic [15:0] obs_addr;
  logic [1:0]  obs_st;
  always_comb begin
    obs_din  = sel_b ? din_b  : din_a;
    obs_wait = sel_b ? wait_b : wait_a;
    obs_req  = sel_b ? req_b  : req_a;
    obs_busy = sel_b ? busy_b : busy_a;
    obs_err  = sel_b ? err_b  : err_a;
    obs_addr = sel_b ? addr_b : addr_a;
    obs_st   = sel_b ? st_b   : st_a;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_din;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // In-range read; the ack is driven in cycle N+1+gap (rd in cycle N).
  task automatic fetch_read(input string tag, input logic [24:0] addr,
                            input logic [7:0] data, input int gap);
    logic stable_ok;
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    mem_dout   = data;
    exp_q.push_back(data);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check({tag, "_req"},   32'(obs_req),  32'd1);
    check({tag, "_wait"},  32'(obs_wait), 32'd1);
    check({tag, "_maddr"}, 32'(obs_addr), 32'(addr[15:0]));
    check({tag, "_state"}, 32'(obs_st),   32'(ST_FETCH));
    stable_ok = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk_sys);
      if (!(obs_wait && obs_req && obs_addr == addr[15:0] && obs_din == exp_din))
        stable_ok = 1'b0;
    end
    check({tag, "_stall"}, 32'(stable_ok), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    exp_din = exp_q.pop_front();
    check({tag, "_din"},      32'(obs_din),  32'(exp_din));
    check({tag, "_wait_low"}, 32'(obs_wait), 32'd0);
    check({tag, "_req_low"},  32'(obs_req),  32'd0);
    @(negedge clk_sys);
    check({tag, "_idle"}, 32'(obs_busy), 32'd0);
  endtask

  // Out-of-range (or checksum) read: data at N+1, no stall, no request.
  task automatic flat_read(input string tag, input logic [24:0] addr, input logic [7:0] exp);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    exp_din  = exp;
    check({tag, "_din"},  32'(obs_din),  32'(exp_din));
    check({tag, "_wait"}, 32'(obs_wait), 32'd0);
    check({tag, "_req"},  32'(obs_req),  32'd0);
    @(negedge clk_sys);
    check({tag, "_wait2"}, 32'(obs_wait | obs_req | obs_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n        = 1'b0;
    ioctl_upload   = 1'b0;
    ioctl_upload_b = 1'b0;
    ioctl_index    = 8'd4;
    ioctl_rd       = 1'b0;
    ioctl_addr     = '0;
    mem_ack        = 1'b0;
    mem_dout       = 8'h00;
    sel_b          = 1'b0;
    exp_din        = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_din",   32'(din_a),  32'h00);
    check("rst_wait",  32'(wait_a), 32'd0);
    check("rst_req",   32'(req_a),  32'd0);
    check("rst_maddr", 32'(addr_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // Ack one cycle after the request, then a 20-cycle stall.
    fetch_read("lat1",  25'd3,     8'h5A, 1);
    fetch_read("lat20", 25'h00040, 8'hC3, 19);

    // Out-of-range read; mem_addr must not move.
    flat_read("oor300", 25'd300, 8'hFF);
    check("oor300_maddr", 32'(addr_a), 32'h0040);

    // No ack: wait held through N+255, released at N+256.
    @(negedge clk_sys);
    ioctl_addr = 25'd5;
    ioctl_rd   = 1'b1;
    mem_dout   = 8'h77;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (254) @(negedge clk_sys);
    check("to_wait_hold", 32'(wait_a), 32'd1);
    check("to_err_pre",   32'(err_a),  32'd0);
    @(negedge clk_sys);
    exp_din = TIMEOUT_BYTE;
    check("to_wait_low", 32'(wait_a), 32'd0);
    check("to_req_low",  32'(req_a),  32'd0);
    check("to_din",      32'(din_a),  32'(exp_din));
    check("to_err",      32'(err_a),  32'd1);
    @(negedge clk_sys);
    check("to_busy", 32'(busy_a), 32'd0);

    // err survives the upload dropping and clears on the next start.
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("err_sticky", 32'(err_a), 32'd1);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("err_clr", 32'(err_a), 32'd0);

    // Upload drops mid-FETCH.
    @(negedge clk_sys);
    ioctl_addr = 25'd7;
    ioctl_rd   = 1'b1;
    mem_dout   = 8'h99;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("abort_req_hi", 32'(req_a), 32'd1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_req",  32'(req_a),  32'd0);
    check("abort_wait", 32'(wait_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_din",  32'(din_a),  32'(exp_din));

    // Wrong index: strobe must be ignored entirely.
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd1;
    @(negedge clk_sys);
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("idx_req",  32'(req_a),  32'd0);
    check("idx_wait", 32'(wait_a), 32'd0);
    check("idx_busy", 32'(busy_a), 32'd0);
    check("idx_din",  32'(din_a),  32'(exp_din));
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd4;

    // Checksum byte on the LEN=3 instance.
    sel_b   = 1'b1;
    exp_din = 8'h00;
    @(negedge clk_sys);
    ioctl_upload_b = 1'b1;
    @(negedge clk_sys);
    fetch_read("b0", 25'd0, 8'h01, 1);
    fetch_read("b1", 25'd1, 8'h02, 3);
    fetch_read("b2", 25'd2, 8'h03, 1);
`ifdef DK_UPLOAD_CSUM_EN
    flat_read("csum", 25'd3, 8'hFA);
`else
    flat_read("csum", 25'd3, 8'hFF);
`endif
    flat_read("b_oor", 25'd4, 8'hFF);
    ioctl_upload_b = 1'b0;
    @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
